// File: rtl/light_cycle_step_ctrl.sv
// Game-step sequencer for the two-player light-cycle game: sweeps the tile map on start,
// then on each tick reads both target tiles, resolves collisions and writes the trails.
module light_cycle_step_ctrl #(
  parameter int MAP_W    = 64,
  parameter int MAP_H    = 48,
  parameter int START_X1 = 10,
  parameter int START_Y1 = 18,
  parameter int START_X2 = 30,
  parameter int START_Y2 = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        tick,
  input  logic [2:0]  dir1,
  input  logic [2:0]  dir2,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_wdata,
  input  logic [1:0]  mem_rdata,
  output logic [2:0]  mode,
  output logic [7:0]  pos_x1,
  output logic [7:0]  pos_y1,
  output logic [7:0]  pos_x2,
  output logic [7:0]  pos_y2,
  output logic        busy
);

  localparam int N_TILES = MAP_W * MAP_H;

  localparam logic [2:0] D_WAIT  = 3'd0;
  localparam logic [2:0] D_RIGHT = 3'd1;
  localparam logic [2:0] D_LEFT  = 3'd2;
  localparam logic [2:0] D_UP    = 3'd3;
  localparam logic [2:0] D_DOWN  = 3'd4;

  localparam logic [1:0] T_EMPTY = 2'd0;
  localparam logic [1:0] T_P1    = 2'd1;
  localparam logic [1:0] T_P2    = 2'd2;
  localparam logic [1:0] T_FRAME = 2'd3;

  localparam logic [2:0] M_START = 3'd0;
  localparam logic [2:0] M_GAME  = 3'd1;
  localparam logic [2:0] M_P1WIN = 3'd2;
  localparam logic [2:0] M_P2WIN = 3'd3;
  localparam logic [2:0] M_OVER  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_PLACE1, S_PLACE2, S_RUN, S_CALC,
    S_RD1, S_RD2, S_CHK, S_WR1, S_WR2, S_END
  } state_t;

  state_t      state_q;
  logic [2:0]  mode_q;
  logic [11:0] mem_addr_q;
  logic        mem_we_q;
  logic [1:0]  mem_wdata_q;
  logic [7:0]  x1_q, y1_q, x2_q, y2_q;
  logic [7:0]  nx1_q, ny1_q, nx2_q, ny2_q;
  logic [2:0]  dir1_q, dir2_q;
  logic [1:0]  tile1_q;

  logic [2:0]  dir1_d, dir2_d;
  logic [7:0]  nx1_d, ny1_d;
  logic        mv1, mv2, same_tgt, crash1, crash2;

  // A reversal request is ignored, as is WAIT or any unused code.
  function automatic logic [2:0] upd_dir(input logic [2:0] cur, input logic [2:0] req);
    logic opp;
    opp = (cur == D_RIGHT && req == D_LEFT) || (cur == D_LEFT && req == D_RIGHT) ||
          (cur == D_UP && req == D_DOWN) || (cur == D_DOWN && req == D_UP);
    if (req == D_WAIT || req > D_DOWN || opp) upd_dir = cur;
    else                                      upd_dir = req;
  endfunction

  function automatic logic [7:0] step_x(input logic [7:0] x, input logic [2:0] d);
    case (d)
      D_RIGHT: step_x = x + 8'd1;
      D_LEFT:  step_x = x - 8'd1;
      default: step_x = x;
    endcase
  endfunction

  function automatic logic [7:0] step_y(input logic [7:0] y, input logic [2:0] d);
    case (d)
      D_DOWN:  step_y = y + 8'd1;
      D_UP:    step_y = y - 8'd1;
      default: step_y = y;
    endcase
  endfunction

  function automatic logic [11:0] tile_addr(input logic [7:0] x, input logic [7:0] y);
    tile_addr = 12'(y) * 12'(MAP_W) + 12'(x);
  endfunction

  function automatic logic [1:0] sweep_tile(input logic [11:0] a);
    int x, y;
    x = int'(a) % MAP_W;
    y = int'(a) / MAP_W;
    sweep_tile = (x == 0 || x == MAP_W - 1 || y == 0 || y == MAP_H - 1) ? T_FRAME : T_EMPTY;
  endfunction

  // Underflow wraps to 255, so a single upper-bound test also catches leaving at 0.
  function automatic logic off_map(input logic [7:0] x, input logic [7:0] y);
    off_map = (x >= 8'(MAP_W)) || (y >= 8'(MAP_H));
  endfunction

  assign dir1_d   = upd_dir(dir1_q, dir1);
  assign dir2_d   = upd_dir(dir2_q, dir2);
  assign nx1_d    = step_x(x1_q, dir1_d);
  assign ny1_d    = step_y(y1_q, dir1_d);
  assign mv1      = (dir1_q != D_WAIT);
  assign mv2      = (dir2_q != D_WAIT);
  assign same_tgt = mv1 && mv2 && (nx1_q == nx2_q) && (ny1_q == ny2_q);
  // tile2 is still on the read port during CHK, so it is used directly.
  assign crash1   = mv1 && (off_map(nx1_q, ny1_q) || tile1_q != T_EMPTY || same_tgt);
  assign crash2   = mv2 && (off_map(nx2_q, ny2_q) || mem_rdata != T_EMPTY || same_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= M_START;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= T_EMPTY;
      x1_q        <= 8'(START_X1);
      y1_q        <= 8'(START_Y1);
      x2_q        <= 8'(START_X2);
      y2_q        <= 8'(START_Y2);
      nx1_q       <= '0;
      ny1_q       <= '0;
      nx2_q       <= '0;
      ny2_q       <= '0;
      dir1_q      <= D_WAIT;
      dir2_q      <= D_WAIT;
      tile1_q     <= T_EMPTY;
    end else begin
      mem_we_q <= 1'b0;
      if (start) begin
        state_q     <= S_CLEAR;
        mode_q      <= M_START;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= '0;
        mem_wdata_q <= sweep_tile(12'd0);
      end else begin
        case (state_q)
          S_IDLE: ;
          S_CLEAR: begin
            mem_we_q <= 1'b1;
            if (mem_addr_q == 12'(N_TILES - 1)) begin
              state_q     <= S_PLACE1;
              mem_addr_q  <= tile_addr(8'(START_X1), 8'(START_Y1));
              mem_wdata_q <= T_P1;
            end else begin
              mem_addr_q  <= mem_addr_q + 12'd1;
              mem_wdata_q <= sweep_tile(mem_addr_q + 12'd1);
            end
          end
          S_PLACE1: begin
            state_q     <= S_PLACE2;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= tile_addr(8'(START_X2), 8'(START_Y2));
            mem_wdata_q <= T_P2;
          end
          S_PLACE2: begin
            state_q <= S_RUN;
            mode_q  <= M_GAME;
            x1_q    <= 8'(START_X1);
            y1_q    <= 8'(START_Y1);
            x2_q    <= 8'(START_X2);
            y2_q    <= 8'(START_Y2);
            dir1_q  <= D_WAIT;
            dir2_q  <= D_WAIT;
          end
          S_RUN: if (tick) state_q <= S_CALC;
          S_CALC: begin
            state_q    <= S_RD1;
            dir1_q     <= dir1_d;
            dir2_q     <= dir2_d;
            nx1_q      <= nx1_d;
            ny1_q      <= ny1_d;
            nx2_q      <= step_x(x2_q, dir2_d);
            ny2_q      <= step_y(y2_q, dir2_d);
            mem_addr_q <= tile_addr(nx1_d, ny1_d);
          end
          S_RD1: begin
            state_q    <= S_RD2;
            mem_addr_q <= tile_addr(nx2_q, ny2_q);
          end
          S_RD2: begin
            state_q <= S_CHK;
            tile1_q <= mem_rdata;
          end
          S_CHK: begin
            if (crash1 || crash2) begin
              state_q <= S_END;
              mode_q  <= (crash1 && crash2) ? M_OVER : (crash1 ? M_P2WIN : M_P1WIN);
            end else begin
              state_q     <= S_WR1;
              mem_we_q    <= mv1;
              mem_addr_q  <= tile_addr(nx1_q, ny1_q);
              mem_wdata_q <= T_P1;
            end
          end
          S_WR1: begin
            state_q     <= S_WR2;
            mem_we_q    <= mv2;
            mem_addr_q  <= tile_addr(nx2_q, ny2_q);
            mem_wdata_q <= T_P2;
          end
          S_WR2: begin
            state_q <= S_RUN;
            x1_q    <= nx1_q;
            y1_q    <= ny1_q;
            x2_q    <= nx2_q;
            y2_q    <= ny2_q;
          end
          S_END: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mode      = mode_q;
  assign pos_x1    = x1_q;
  assign pos_y1    = y1_q;
  assign pos_x2    = x2_q;
  assign pos_y2    = y2_q;
  assign busy      = !(state_q == S_IDLE || state_q == S_RUN || state_q == S_END);

endmodule
